// File: rtl/regfile_pkg.sv
// Shared widths, register-0 index and grant encoding for the register-file writeback arbiter.
// Used by regfile_wb_arbiter and its optional bypass mux (REGFILE_WB_BYPASS_EN).
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    // Wide enough for the largest supported starvation limit (15).
    localparam int WAIT_W   = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_0    = 2'b01,
        GNT_1    = 2'b10
    } gnt_e;

    // Fixed priority to req0 unless req1 has already lost MAX_WAIT cycles in a row.
    function automatic gnt_e pick_grant(input logic v0, input logic v1, input logic starved);
        if (v1 && starved) begin
            return GNT_1;
        end else if (v0) begin
            return GNT_0;
        end else if (v1) begin
            return GNT_1;
        end
        return GNT_NONE;
    endfunction

endpackage

// File: rtl/regfile_wb_fwd.sv
// Read-port bypass mux: substitutes the in-flight RegisterFile write for a matching read index.
// Instantiated by regfile_wb_arbiter only when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_fwd #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_rd,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] fwd
);
    import regfile_pkg::*;

    // Register 0 is hard-wired, so a pending write to it must never be forwarded.
    assign fwd = (wr_en && (wr_rd == rs) && (rs != ADDR_W'(ZERO_REG))) ? wr_data : rdata;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester arbiter for the single RegisterFile write port (ALU vs load writeback).
// Define REGFILE_WB_BYPASS_EN to add the rs/rt read-bypass ports (A_fwd/B_fwd).
module regfile_wb_arbiter #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_dataIn,
    output logic              starve_q
`ifdef REGFILE_WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    output logic [DATA_W-1:0] A_fwd,
    output logic [DATA_W-1:0] B_fwd
`endif
);
    import regfile_pkg::*;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    gnt_e              gnt;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt = GNT_NONE;
        // Nothing handshakes while reset is held, even with valids already high.
        if (rst) begin
            gnt = pick_grant(req0_valid, req1_valid, wait_cnt == WAIT_MAX);
        end
    end

    assign req0_ready = (gnt == GNT_0);
    assign req1_ready = (gnt == GNT_1);
    assign starve_q   = (wait_cnt == WAIT_MAX);

    assign win_rd   = (gnt == GNT_1) ? req1_rd   : req0_rd;
    assign win_data = (gnt == GNT_1) ? req1_data : req0_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!req1_valid || req1_ready) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Registered write port: rf_* depend only on flops, never on the valid inputs directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_dataIn <= '0;
        end else if (gnt != GNT_NONE) begin
            rf_we     <= (win_rd != ADDR_W'(ZERO_REG));
            rf_rd     <= win_rd;
            rf_dataIn <= win_data;
        end else begin
            rf_we     <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    regfile_wb_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_a (
        .wr_en   (rf_we),
        .wr_rd   (rf_rd),
        .wr_data (rf_dataIn),
        .rs      (rs),
        .rdata   (A_in),
        .fwd     (A_fwd)
    );

    regfile_wb_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd_b (
        .wr_en   (rf_we),
        .wr_rd   (rf_rd),
        .wr_data (rf_dataIn),
        .rs      (rt),
        .rdata   (B_in),
        .fwd     (B_fwd)
    );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model; bypass checks only when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk        = 1'b0;
    logic              rst        = 1'b0;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_rd    = '0;
    logic [DATA_W-1:0] req0_data  = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_rd    = '0;
    logic [DATA_W-1:0] req1_data  = '0;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_dataIn;
    logic              starve_q;
`ifdef REGFILE_WB_BYPASS_EN
    logic [ADDR_W-1:0] rs   = '0;
    logic [ADDR_W-1:0] rt   = '0;
    logic [DATA_W-1:0] A_in = '0;
    logic [DATA_W-1:0] B_in = '0;
    logic [DATA_W-1:0] A_fwd;
    logic [DATA_W-1:0] B_fwd;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_dataIn  (rf_dataIn),
        .starve_q   (starve_q)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .rs         (rs),
        .rt         (rt),
        .A_in       (A_in),
        .B_in       (B_in),
        .A_fwd      (A_fwd),
        .B_fwd      (B_fwd)
`endif
    );

    // RegisterFile stand-in, fed only by the DUT's write port.
    logic [DATA_W-1:0] bench_rf [32] = '{default: '0};
    always @(posedge clk) begin
        if (rf_we) bench_rf[rf_rd] <= rf_dataIn;
    end

    // Requesters must keep rd/data stable while stalled.
    logic              p0_hold = 1'b0, p1_hold = 1'b0;
    logic [ADDR_W-1:0] p0_rd, p1_rd;
    logic [DATA_W-1:0] p0_data, p1_data;
    always @(posedge clk) begin
        if (rst && p0_hold)
            assert (req0_valid && req0_rd == p0_rd && req0_data == p0_data)
                else $error("req0 changed while stalled");
        if (rst && p1_hold)
            assert (req1_valid && req1_rd == p1_rd && req1_data == p1_data)
                else $error("req1 changed while stalled");
        p0_hold <= rst && req0_valid && !req0_ready;
        p1_hold <= rst && req1_valid && !req1_ready;
        p0_rd   <= req0_rd;
        p0_data <= req0_data;
        p1_rd   <= req1_rd;
        p1_data <= req1_data;
    end

    // Reference model state: what the write port should show, and the architectural registers.
    int                m_lost = 0;
    bit                m_we   = 1'b0;
    logic [ADDR_W-1:0] m_rd   = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [DATA_W-1:0] m_regs [32] = '{default: '0};

    bit                g0, g1;
    logic              obs_r0, obs_r1, obs_we, obs_starve;
    logic [ADDR_W-1:0] obs_rd;
    logic [DATA_W-1:0] obs_data;

    task automatic assert_reset();
        rst    = 1'b0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_lost = 0;
    endtask

    // One clock: observe at the falling edge, compare against the model, advance the model.
    task automatic model_cycle(input string tag);
        logic [ADDR_W-1:0] w_rd;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (rst) begin
            if (req1_valid && m_lost >= MAX_WAIT) g1 = 1'b1;
            else if (req0_valid)                 g0 = 1'b1;
            else if (req1_valid)                 g1 = 1'b1;
        end
        obs_r0 = req0_ready;  obs_r1 = req1_ready;  obs_we = rf_we;
        obs_rd = rf_rd;       obs_data = rf_dataIn; obs_starve = starve_q;
        checks++;
        if (obs_r0 !== g0) begin errors++; $display("FAIL %s req0_ready: got %b want %b", tag, obs_r0, g0); end
        checks++;
        if (obs_r1 !== g1) begin errors++; $display("FAIL %s req1_ready: got %b want %b", tag, obs_r1, g1); end
        checks++;
        if (obs_we !== m_we) begin errors++; $display("FAIL %s rf_we: got %b want %b", tag, obs_we, m_we); end
        checks++;
        if (obs_rd !== m_rd) begin errors++; $display("FAIL %s rf_rd: got %0d want %0d", tag, obs_rd, m_rd); end
        checks++;
        if (obs_data !== m_data) begin errors++; $display("FAIL %s rf_dataIn: got %h want %h", tag, obs_data, m_data); end
        checks++;
        if (obs_starve !== (m_lost == MAX_WAIT)) begin
            errors++; $display("FAIL %s starve_q: got %b want %b", tag, obs_starve, m_lost == MAX_WAIT);
        end
        if (rst) begin
            if (m_we) m_regs[m_rd] = m_data;
            if (g0 || g1) begin
                w_rd   = g0 ? req0_rd : req1_rd;
                m_rd   = w_rd;
                m_data = g0 ? req0_data : req1_data;
                m_we   = (w_rd != 0);
            end else begin
                m_we = 1'b0;
            end
            if (!req1_valid || g1) m_lost = 0;
            else if (m_lost < MAX_WAIT) m_lost++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = $urandom;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = $urandom;
        assert_reset();
        for (int i = 0; i < 3; i++) begin
            model_cycle("reset_hold");
            checks++;
            if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || obs_we !== 1'b0 || obs_rd !== '0 || obs_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got r0=%b r1=%b we=%b rd=%0d data=%h want all zero",
                         obs_r0, obs_r1, obs_we, obs_rd, obs_data);
            end
        end
        rst = 1'b1;
        model_cycle("reset_release");
        checks++;
        if (obs_r0 !== 1'b1) begin errors++; $display("FAIL reset_first_grant: got req0_ready=%b want 1", obs_r0); end
        req0_valid = 1'b0;
        model_cycle("reset_req1");
        req1_valid = 1'b0;
        model_cycle("reset_idle");
        model_cycle("reset_idle");
    endtask

    task automatic test_single_writes();
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'd2001;
        model_cycle("single_a");
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'd4001;
        model_cycle("single_b");
        checks++;
        if (obs_we !== 1'b1 || obs_rd !== 5'd1 || obs_data !== 32'd2001) begin
            errors++; $display("FAIL single_wr0: got we=%b rd=%0d data=%0d want 1/1/2001", obs_we, obs_rd, obs_data);
        end
        req1_valid = 1'b0;
        model_cycle("single_c");
        checks++;
        if (obs_we !== 1'b1 || obs_rd !== 5'd2 || obs_data !== 32'd4001) begin
            errors++; $display("FAIL single_wr1: got we=%b rd=%0d data=%0d want 1/2/4001", obs_we, obs_rd, obs_data);
        end
        model_cycle("single_d");
        checks++;
        if (bench_rf[1] !== 32'd2001 || bench_rf[2] !== 32'd4001) begin
            errors++; $display("FAIL single_read: got A=%0d B=%0d want 2001/4001", bench_rf[1], bench_rf[2]);
        end
    endtask

    task automatic test_zero_reg();
        req0_valid = 1'b1; req0_rd = 5'd0; req0_data = 32'd8002;
        model_cycle("zero_a");
        checks++;
        if (obs_r0 !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b want 1", obs_r0); end
        req0_valid = 1'b0;
        model_cycle("zero_b");
        checks++;
        if (obs_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", obs_we); end
        model_cycle("zero_c");
        checks++;
        if (bench_rf[0] !== '0) begin errors++; $display("FAIL zero_reg_value: got %h want 0", bench_rf[0]); end
    endtask

    task automatic test_starvation();
        int denied  = 0;
        bit granted = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd6; req0_data = $urandom;
        req1_valid = 1'b1; req1_rd = 5'd8; req1_data = 32'd3002;
        for (int i = 0; i < 10 && !granted; i++) begin
            model_cycle("starve");
            if (obs_r1 === 1'b1) begin
                granted = 1'b1;
                checks++;
                if (obs_starve !== 1'b1) begin errors++; $display("FAIL starve_flag: got %b want 1", obs_starve); end
            end else begin
                denied++;
                req0_data = $urandom;
            end
        end
        checks++;
        if (!granted || denied != MAX_WAIT) begin
            errors++; $display("FAIL starve_denials: got granted=%b denied=%0d want 1/%0d", granted, denied, MAX_WAIT);
        end
        req1_valid = 1'b0;
        model_cycle("starve_out");
        checks++;
        if (obs_we !== 1'b1 || obs_rd !== 5'd8 || obs_data !== 32'd3002 || obs_starve !== 1'b0) begin
            errors++;
            $display("FAIL starve_write: got we=%b rd=%0d data=%0d starve=%b want 1/8/3002/0",
                     obs_we, obs_rd, obs_data, obs_starve);
        end
        req0_valid = 1'b0;
        model_cycle("starve_idle");
        model_cycle("starve_idle");
    endtask

    task automatic test_collision();
        req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'h11;
        req1_valid = 1'b1; req1_rd = 5'd6; req1_data = 32'h22;
        model_cycle("coll_a");
        req0_valid = 1'b0;
        model_cycle("coll_b");
        checks++;
        if (obs_r1 !== 1'b1 || obs_data !== 32'h11) begin
            errors++; $display("FAIL coll_first: got r1=%b data=%h want 1/11", obs_r1, obs_data);
        end
        req1_valid = 1'b0;
        model_cycle("coll_c");
        checks++;
        if (obs_we !== 1'b1 || obs_data !== 32'h22) begin
            errors++; $display("FAIL coll_second: got we=%b data=%h want 1/22", obs_we, obs_data);
        end
        model_cycle("coll_d");
        checks++;
        if (bench_rf[6] !== 32'h22) begin errors++; $display("FAIL coll_final: got %h want 22", bench_rf[6]); end
    endtask

    task automatic test_midop_reset();
        bit pulsed = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h5A5A;
        model_cycle("midrst_xfer");
        req0_valid = 1'b0;
        assert_reset();
        for (int i = 0; i < 2; i++) begin
            model_cycle("midrst_hold");
            if (obs_we !== 1'b0) pulsed = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_cycle("midrst_after");
            if (obs_we !== 1'b0) pulsed = 1'b1;
        end
        checks++;
        if (pulsed || bench_rf[9] !== '0) begin
            errors++; $display("FAIL midrst_cancel: got pulsed=%b reg9=%h want 0/0", pulsed, bench_rf[9]);
        end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    task automatic test_bypass();
        logic [DATA_W-1:0] raw;
        req0_valid = 1'b1; req0_rd = 5'd6; req0_data = 32'd8002;
        model_cycle("byp_xfer");
        req0_valid = 1'b0;
        rs = 5'd6; A_in = '0; rt = 5'd5; raw = $urandom; B_in = raw;
        #1;
        checks++;
        if (A_fwd !== 32'd8002) begin errors++; $display("FAIL bypass_hit: got %0d want 8002", A_fwd); end
        checks++;
        if (B_fwd !== raw) begin errors++; $display("FAIL bypass_miss: got %h want %h", B_fwd, raw); end
        rs = 5'd0; raw = $urandom; A_in = raw;
        #1;
        checks++;
        if (A_fwd !== raw) begin errors++; $display("FAIL bypass_zero: got %h want %h", A_fwd, raw); end
        model_cycle("byp_idle");
        model_cycle("byp_idle");
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || g0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_rd    = ADDR_W'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!req1_valid || g1) begin
                req1_valid = ($urandom_range(0, 1) != 0);
                req1_rd    = ADDR_W'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            model_cycle("random");
        end
        if (g0) req0_valid = 1'b0;
        if (g1) req1_valid = 1'b0;
        for (int i = 0; i < 20 && (req0_valid || req1_valid); i++) begin
            model_cycle("drain");
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end
        model_cycle("random_idle");
        model_cycle("random_idle");
        for (int r = 0; r < 32; r++) begin
            checks++;
            if (bench_rf[r] !== m_regs[r]) begin
                errors++; $display("FAIL random_reg%0d: got %h want %h", r, bench_rf[r], m_regs[r]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_writes();
        test_zero_reg();
        test_starvation();
        test_collision();
        test_midop_reset();
`ifdef REGFILE_WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single RegisterFile write port (we/rd/dataIn) between two writeback requesters: req0 (ALU writeback) and req1 (load writeback).
- Each requester uses a valid/ready handshake.
- Fixed priority goes to req0, with a starvation guard that promotes req1 after MAX_WAIT lost cycles.
- The winning request is registered and presented to RegisterFile one cycle later. Writes to register 0 are consumed but suppressed.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width.
- MAX_WAIT, 4, consecutive cycles req1 may be denied before it takes priority; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_rd  in  ADDR_W  ALU destination register.
- req0_data  in  DATA_W  ALU result.
- req0_ready  out  1  req0 granted this cycle.
- req1_valid  in  1  load writeback request.
- req1_rd  in  ADDR_W  load destination register.
- req1_data  in  DATA_W  load data.
- req1_ready  out  1  req1 granted this cycle.
- rf_we  out  1  RegisterFile write enable.
- rf_rd  out  ADDR_W  RegisterFile write index.
- rf_dataIn  out  DATA_W  RegisterFile write data.
- starve_q  out  1  wait counter has reached MAX_WAIT (debug).

Behaviour:
- **Reset.** While rst=0, the following are all 0: rf_we, rf_rd, rf_dataIn, wait counter, starve_q, req0_ready, req1_ready.
  - Reset asserted mid-operation cancels any registered write; no write reaches RegisterFile on the following edge.
- **Grant logic** (combinational from valids and counter), at most one grant per cycle:
  - If req1_valid and wait_cnt==MAX_WAIT: grant req1.
  - Else if req0_valid: grant req0.
  - Else if req1_valid: grant req1.
  - Else: no grant.
- **Transfer.** reqN_ready equals grantN. A transfer occurs when valid&&ready.
  - Requesters hold rd and data stable while valid && !ready; the bench asserts this.
- **Wait counter** (0..MAX_WAIT, saturating):
  - Increments when req1_valid && !req1_ready.
  - Clears when req1 is granted or req1_valid=0.
  - starve_q = (wait_cnt==MAX_WAIT).
- **Output stage** (1 cycle latency):
  - On the edge after a transfer: rf_rd and rf_dataIn load the winner's rd and data; rf_we=1 if rd!=0, else 0.
  - No transfer: rf_we=0; rf_rd and rf_dataIn hold their previous values.
  - RegisterFile samples on the next edge, so the register is visible to reads 2 edges after the transfer.
- **Same rd from both requesters in one cycle:** loser writes later. The final value is the later grant's data; write order equals grant order.
- **Back-to-back:** a continuous req0 stream gets 100% of the port except one slot per MAX_WAIT+1 cycles while req1 is pending.
- **No combinational path** from the valid inputs to rf_*.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- When defined, adds the following ports:
  - Inputs: rs, rt (ADDR_W each) and A_in, B_in (DATA_W each, raw RegisterFile read outputs).
  - Outputs: A_fwd, B_fwd (DATA_W each).
- Forwarding rule: A_fwd = rf_dataIn if rf_we && rf_rd==rs && rs!=0, else A_in. B_fwd follows the same rule with rt/B_in.
  - Purely combinational; gives same-cycle visibility of the in-flight write.
- When undefined: these ports are absent and reads see a write only after the RegisterFile edge.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, ZERO_REG=0.
  - Grant encoding constants GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10.
- One natural sub-module: regfile_wb_fwd, the bypass mux instantiated twice, only under REGFILE_WB_BYPASS_EN.

Test Plan:
1. **Reset.** rst=0 for 3 cycles with both valids high -> both readies 0, rf_we=0, rf_rd=0, rf_dataIn=0.
   - Release rst -> req0 is granted in the first cycle.
2. **Single writes.** req0 {rd=1, data=2001} for one cycle, then req1 {rd=2, data=4001} -> rf_we pulses with (1,2001) then (2,4001).
   - Reading rs=1, rt=2 through RegisterFile afterwards returns A=2001, B=4001.
3. **Zero register.** req0 {rd=0, data=8002} -> req0_ready=1, rf_we stays 0 next cycle, register 0 unchanged.
4. **Starvation guard.** req0 valid continuously with rd=6; req1 {rd=8, data=3002} held valid, MAX_WAIT=4.
   - req1 is denied for 4 cycles, starve_q=1, then req1_ready=1 on the 5th.
   - Next cycle rf_we=1, rf_rd=8, rf_dataIn=3002; counter returns to 0.
5. **Collision and mid-operation reset.**
   - Both requesters target rd=6 in the same cycle (0x11 from req0, 0x22 from req1) -> final register 6 = 0x22.
   - Separately, rst asserted the cycle after a transfer -> rf_we never pulses.
6. **Bypass** (with REGFILE_WB_BYPASS_EN). rf_we=1, rf_rd=6, rf_dataIn=8002, rs=6, A_in=0 -> A_fwd=8002.
   - rs=0 -> A_fwd=A_in.
